// File: rtl/lives_controller.sv
// Player life counter with a post-hit invulnerability window and a blinking life-icon enable.
// Every output is registered, so each response appears one clock after its input is sampled.
module lives_controller #(
  parameter int INIT_LIVES    = 3,
  parameter int MAX_LIVES     = 5,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               hit,
  input  logic               bonus,
  input  logic               newGame,
  output logic signed [15:0] lives,
  output logic               visible,
  output logic               invulnerable,
  output logic               gameOver
);

  localparam int FW = (INVULN_FRAMES < 1) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam int BW = (BLINK_FRAMES < 1) ? 1 : $clog2(BLINK_FRAMES + 1);
  localparam logic signed [15:0] INIT_L = INIT_LIVES[15:0];
  localparam logic signed [15:0] MAX_L  = MAX_LIVES[15:0];

  typedef enum logic [1:0] {PLAY, INVULN, GAME_OVER} state_t;

  state_t               state_q, state_d;
  logic signed [15:0]   lives_q, lives_d;
  logic [FW-1:0]        frame_q, frame_d;
  logic [BW-1:0]        blink_q, blink_d;
  logic                 visible_q, visible_d;
  logic                 invuln_q, gameover_q;

  function automatic logic signed [15:0] sat_inc(input logic signed [15:0] l);
    if (l >= MAX_L) return MAX_L;
    return l + 16'sd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= PLAY;
      invuln_q   <= 1'b0;
      gameover_q <= 1'b0;
      lives_q    <= INIT_L;
      frame_q    <= '0;
      blink_q    <= '0;
      visible_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      invuln_q   <= (state_d == INVULN);
      gameover_q <= (state_d == GAME_OVER);
      lives_q    <= lives_d;
      frame_q    <= frame_d;
      blink_q    <= blink_d;
      visible_q  <= visible_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (newGame) begin
      state_d = PLAY;
    end else begin
      case (state_q)
        PLAY:      if (hit) state_d = (bonus || lives_q > 16'sd1) ? INVULN : GAME_OVER;
        INVULN:    if (startOfFrame && frame_q == FW'(1)) state_d = PLAY;
        GAME_OVER: state_d = GAME_OVER;
        default:   state_d = PLAY;
      endcase
    end
  end

  always_comb begin
    lives_d   = lives_q;
    frame_d   = frame_q;
    blink_d   = blink_q;
    visible_d = visible_q;
    if (newGame) begin
      lives_d   = INIT_L;
      frame_d   = '0;
      blink_d   = '0;
      visible_d = 1'b1;
    end else begin
      case (state_q)
        PLAY: begin
          visible_d = 1'b1;
          if (hit) begin
            if (bonus || lives_q > 16'sd1) begin
              // hit+bonus cancels out: lose one, gain one, still capped
              lives_d   = bonus ? sat_inc(lives_q - 16'sd1) : lives_q - 16'sd1;
              frame_d   = FW'(INVULN_FRAMES);
              blink_d   = '0;
              visible_d = 1'b0;
            end else begin
              lives_d = 16'sd0;
            end
          end else if (bonus) begin
            lives_d = sat_inc(lives_q);
          end
        end
        INVULN: begin
          if (bonus) lives_d = sat_inc(lives_q);
          if (startOfFrame) begin
            if (frame_q == FW'(1)) begin
              frame_d   = '0;
              blink_d   = '0;
              visible_d = 1'b1;
            end else begin
              frame_d = frame_q - FW'(1);
              if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                blink_d   = '0;
                visible_d = ~visible_q;
              end else begin
                blink_d = blink_q + BW'(1);
              end
            end
          end
        end
        GAME_OVER: begin
          lives_d   = 16'sd0;
          visible_d = 1'b1;
        end
        default: begin
          lives_d   = INIT_L;
          visible_d = 1'b1;
        end
      endcase
    end
  end

  assign lives        = lives_q;
  assign visible      = visible_q;
  assign invulnerable = invuln_q;
  assign gameOver     = gameover_q;

endmodule
